i2c_codec_target: RTL
=====================

Name: i2c_codec_target

Overview:
- Synthesizable I2C target (responder) modelling the audio codec's write-only control port: decodes 3-byte writes (device address, register/data-MSB, data-LSB) and updates a 10-entry 9-bit register file.
- Sits opposite the init/i2c controller pair on the SDAT/SDCLK lines. Used on-chip as the codec stand-in for simulation and loopback bring-up, and for exposing written codec settings to other logic.

Parameters:
- ADDRESS, 7'b0011010, 7-bit device address the block responds to.
- SYNC_STAGES, 2, flip-flop stages synchronizing SDCLK and SDAT into clk (min 2).

Ports:
- clk, input, 1, system clock; must be at least 8x the SDCLK rate.
- rst, input, 1, asynchronous active-low reset.
- SDCLK, input, 1, I2C clock from the initiator.
- SDAT, inout, 1, I2C data line, open-drain: driven 0 when acking, otherwise 1'bz.
- regWrite, output, 1, one-cycle pulse on each completed write frame.
- regAddr, output, 7, register index of the last completed write.
- regData, output, 9, data value of the last completed write.
- rdAddr, input, 4, register-file read index.
- rdData, output, 9, combinational read of entry rdAddr; 0 when rdAddr > 9.
- active, output, 1, bit 0 of register 9 (Activate Control).
- frameError, output, 1, one-cycle pulse when a START or STOP aborts an addressed frame before commit.
- busy, output, 1, high from an address match until the following STOP or START.

Behaviour:
- Reset (rst=0, async):
  - SDAT released; regWrite=0, frameError=0, busy=0, regAddr=0, regData=0; FSM in IDLE; bit counter cleared.
  - Register file loaded with defaults R0..R9 = 0x097, 0x097, 0x079, 0x079, 0x00A, 0x008, 0x09F, 0x00A, 0x000, 0x000.
  - Reset mid-frame releases SDAT immediately.
- Sampling:
  - SDCLK and SDAT each pass through SYNC_STAGES flops. A one-cycle-delayed copy of each gives edge detection: sclRise, sclFall, sdaRise, sdaFall.
  - START = sdaFall while synced SCL is high. STOP = sdaRise while synced SCL is high. START/STOP take priority over bit handling in the same cycle.
  - Data bits are shifted MSB first on sclRise.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE: on START go to ADDR with bit counter 0. All other events are ignored.
  - ADDR: shift 8 bits. After the 8th sclRise, compare byte[7:1] with ADDRESS and require byte[0]=0 (write).
    - Match: busy<=1, go to ADDR_ACK.
    - Mismatch or read request: go to IGNORE.
  - Each ACK state: on the first sclFall, drive SDAT low. On the next sclFall, release SDAT and advance. A release and a new drive never happen in the same cycle.
    - ADDR_ACK advances to REG.
    - REG_ACK advances to DATA.
    - DATA_ACK advances to IGNORE.
  - REG: shift 8 bits; latch reg = byte[7:1] and data[8] = byte[0].
  - DATA: shift 8 bits; data[7:0] = byte. The cycle after the 8th sclRise:
    - commit: regWrite=1 for one cycle, with regAddr/regData updated in that same cycle;
    - enter DATA_ACK.
  - IGNORE: SDAT stays released, including for any further bytes (they are not acked). Leave only on START or STOP.
- Commit rules:
  - reg 0..9: entry updated with data.
  - reg 15 (0x0F): all entries return to their defaults; regWrite still pulses with regAddr=15.
  - reg 10..14 and 16..127: acked and pulsed, register file unchanged.
- START in any non-IDLE state: go to ADDR, release SDAT, busy<=0 (repeated start).
- STOP in any state: go to IDLE, release SDAT, busy<=0.
- frameError pulses when START or STOP arrives while the FSM is in ADDR_ACK, REG, REG_ACK, or DATA before commit. No write occurs in that case.
- Latency: pin edge to internal event is SYNC_STAGES+1 clk. Commit occurs SYNC_STAGES+2 clk after the SDCLK rising edge of the last data bit.
- Commit and an rdAddr read of the same entry in the same cycle: rdData shows the old value; the new value appears next cycle.

Test Plan:
- Write reg 6 = 0x010 (bytes 0x34, 0x0C, 0x10, then STOP): three ACKs with SDAT low during each 9th SCL-high phase; one regWrite pulse with regAddr=6, regData=0x010; rdAddr=6 gives 0x010; busy falls after STOP.
- Write reg 9 = 0x001 (0x34, 0x12, 0x01): active=1. Then write reg 15 = 0x000 (0x34, 0x1E, 0x00): active=0; rdAddr=0 gives 0x097; regWrite pulses with regAddr=15.
- Wrong address byte 0x36, and read byte 0x35: SDAT never driven low; no regWrite; busy stays 0.
- Aborted frame (0x34, 0x0C, then STOP): frameError pulses once; no regWrite; rdAddr=6 still 0x09F.
- Repeated START after the 0x34 ACK, followed by the full frame 0x34, 0x0E, 0xFF: a single regWrite with regAddr=7, regData=0x0FF; frameError pulses once for the interrupted frame.
- rst asserted while SDAT is driven low in REG_ACK: SDAT is 1'bz in the same cycle; all outputs at reset values; register file back to defaults.

Source files
------------

// File: rtl/i2c_codec_target.sv
// Write-only I2C target standing in for the audio codec control port.
// It decodes {device addr, reg[6:0]/data[8], data[7:0]} frames into a 10 x 9-bit register file.
module i2c_codec_target #(
  parameter logic [6:0] ADDRESS     = 7'b0011010,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SDCLK,
  inout  wire        SDAT,
  output logic       regWrite,
  output logic [6:0] regAddr,
  output logic [8:0] regData,
  input  logic [3:0] rdAddr,
  output logic [8:0] rdData,
  output logic       active,
  output logic       frameError,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE} state_t;

  function automatic logic [8:0] rf_default(input int idx);
    case (idx)
      0, 1:    rf_default = 9'h097;
      2, 3:    rf_default = 9'h079;
      4, 7:    rf_default = 9'h00A;
      5:       rf_default = 9'h008;
      6:       rf_default = 9'h09F;
      default: rf_default = 9'h000;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_d1_q, sda_d1_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]             byte_nx;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_phase_q, ack_phase_d;
  logic       pend_q, pend_d;
  logic [6:0] reg_q, reg_d;
  logic [8:0] data_q, data_d;
  logic [6:0] regAddr_q, regAddr_d;
  logic [8:0] regData_q, regData_d;
  logic       regWrite_q, regWrite_d;
  logic       frameError_q, frameError_d;
  logic       busy_q, busy_d;
  logic [8:0] rf_q [10];
  logic [8:0] rf_d [10];

  assign SDAT = sda_oe_q ? 1'b0 : 1'bz;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d1_q;
  assign scl_fall = ~scl_s & scl_d1_q;
  assign start_ev = ~sda_s & sda_d1_q & scl_s;
  assign stop_ev  = sda_s & ~sda_d1_q & scl_s;
  assign byte_nx  = {shift_q[6:0], sda_s};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    ack_phase_d  = ack_phase_q;
    pend_d       = 1'b0;
    reg_d        = reg_q;
    data_d       = data_q;
    regAddr_d    = regAddr_q;
    regData_d    = regData_q;
    regWrite_d   = 1'b0;
    frameError_d = 1'b0;
    busy_d       = busy_q;
    rf_d         = rf_q;

    if (start_ev || stop_ev) begin
      // Anything between the address ack and the commit is a half-delivered write.
      frameError_d = (state_q == ADDR_ACK) || (state_q == REG) ||
                     (state_q == REG_ACK) || (state_q == DATA);
      sda_oe_d     = 1'b0;
      ack_phase_d  = 1'b0;
      busy_d       = 1'b0;
      bit_cnt_d    = 3'd0;
      state_d      = start_ev ? ADDR : IDLE;
    end else begin
      case (state_q)
        ADDR, REG, DATA: begin
          if (pend_q) begin
            regWrite_d = 1'b1;
            regAddr_d  = reg_q;
            regData_d  = data_q;
            if (reg_q < 7'd10) begin
              rf_d[reg_q[3:0]] = data_q;
            end else if (reg_q == 7'd15) begin
              for (int i = 0; i < 10; i++) rf_d[i] = rf_default(i);
            end
            state_d = DATA_ACK;
          end else if (scl_rise) begin
            shift_d   = byte_nx;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ADDR) begin
                if (byte_nx[7:1] == ADDRESS && !byte_nx[0]) begin
                  busy_d  = 1'b1;
                  state_d = ADDR_ACK;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == REG) begin
                reg_d     = byte_nx[7:1];
                data_d[8] = byte_nx[0];
                state_d   = REG_ACK;
              end else begin
                data_d[7:0] = byte_nx;
                pend_d      = 1'b1;
              end
            end
          end
        end
        ADDR_ACK, REG_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              bit_cnt_d   = 3'd0;
              state_d     = (state_q == ADDR_ACK) ? REG :
                            (state_q == REG_ACK)  ? DATA : IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_d1_q     <= 1'b1;
      sda_d1_q     <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      sda_oe_q     <= 1'b0;
      ack_phase_q  <= 1'b0;
      pend_q       <= 1'b0;
      reg_q        <= 7'd0;
      data_q       <= 9'd0;
      regAddr_q    <= 7'd0;
      regData_q    <= 9'd0;
      regWrite_q   <= 1'b0;
      frameError_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < 10; i++) rf_q[i] <= rf_default(i);
    end else begin
      scl_sync_q   <= {scl_sync_q[SYNC_STAGES-2:0], SDCLK};
      sda_sync_q   <= {sda_sync_q[SYNC_STAGES-2:0], SDAT};
      scl_d1_q     <= scl_s;
      sda_d1_q     <= sda_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      ack_phase_q  <= ack_phase_d;
      pend_q       <= pend_d;
      reg_q        <= reg_d;
      data_q       <= data_d;
      regAddr_q    <= regAddr_d;
      regData_q    <= regData_d;
      regWrite_q   <= regWrite_d;
      frameError_q <= frameError_d;
      busy_q       <= busy_d;
      rf_q         <= rf_d;
    end
  end

  assign regWrite   = regWrite_q;
  assign regAddr    = regAddr_q;
  assign regData    = regData_q;
  assign frameError = frameError_q;
  assign busy       = busy_q;
  assign active     = rf_q[9][0];
  assign rdData     = (rdAddr > 4'd9) ? 9'd0 : rf_q[rdAddr];
endmodule
